// File: rtl/genius_sequencer_if.sv
// Signal bundle between the Genius controller, the button processor and the LED/status outputs.
interface genius_sequencer_if;
   logic       start;
   logic       valid_press;
   logic [1:0] decoded_input;
   logic       player_wr;
   logic       led_green;
   logic       led_red;
   logic       led_blue;
   logic       led_yellow;
   logic       game_over;
   logic       win;
   logic [5:0] score;

   modport master (
      output start, valid_press, decoded_input,
      input  player_wr, led_green, led_red, led_blue, led_yellow, game_over, win, score
   );

   modport slave (
      input  start, valid_press, decoded_input,
      output player_wr, led_green, led_red, led_blue, led_yellow, game_over, win, score
   );
endinterface

// File: rtl/genius_sequencer.sv
// Genius (Simon) game FSM: grows a random colour sequence, plays it back, then checks player presses.
// Moore outputs only; a press is judged in the cycle valid_press is high, result visible one cycle later.
module genius_sequencer #(
   parameter int         MAX_LEN       = 16,
   parameter int         SHOW_TICKS    = 25_000_000,
   parameter int         GAP_TICKS     = 12_500_000,
   parameter int         TIMEOUT_TICKS = 250_000_000,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   genius_sequencer_if.slave bus
);
   localparam int MAX_SG = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int MAX_T  = (MAX_SG > TIMEOUT_TICKS) ? MAX_SG : TIMEOUT_TICKS;
   localparam int TW     = $clog2(MAX_T + 1);
   localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_INPUT, S_PAUSE, S_LOSE, S_WIN
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    mem [MAX_LEN];
   logic [5:0]    len, len_nxt;
   logic [5:0]    idx, idx_nxt;
   logic [5:0]    score, score_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [7:0]    lfsr;
   logic          mem_we;
   logic [1:0]    cur;
   logic          last_step;
   logic [3:0]    led_sel;

   assign cur       = mem[idx[AW-1:0]];
   assign last_step = (idx == len - 6'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         len   <= '0;
         idx   <= '0;
         timer <= '0;
         score <= '0;
         lfsr  <= LFSR_SEED;
      end else begin
         state <= state_nxt;
         len   <= len_nxt;
         idx   <= idx_nxt;
         timer <= timer_nxt;
         score <= score_nxt;
         lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   // Sequence contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[len[AW-1:0]] <= lfsr[1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      idx_nxt   = idx;
      timer_nxt = timer;
      score_nxt = score;
      mem_we    = 1'b0;
      case (state)
         S_IDLE, S_LOSE, S_WIN: begin
            if (bus.start) begin
               len_nxt   = '0;
               score_nxt = '0;
               state_nxt = S_ADD;
            end
         end
         S_ADD: begin
            mem_we    = 1'b1;
            len_nxt   = len + 6'd1;
            idx_nxt   = '0;
            timer_nxt = '0;
            state_nxt = S_SHOW_ON;
         end
         S_SHOW_ON: begin
            if (timer == SHOW_LAST) begin
               timer_nxt = '0;
               state_nxt = S_SHOW_OFF;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_SHOW_OFF: begin
            if (timer == GAP_LAST) begin
               timer_nxt = '0;
               if (last_step) begin
                  idx_nxt   = '0;
                  state_nxt = S_WAIT_INPUT;
               end else begin
                  idx_nxt   = idx + 6'd1;
                  state_nxt = S_SHOW_ON;
               end
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_WAIT_INPUT: begin
            // A press in the timeout cycle takes priority over the timeout.
            if (bus.valid_press) begin
               timer_nxt = '0;
               if (bus.decoded_input != cur) begin
                  state_nxt = S_LOSE;
               end else if (last_step) begin
                  score_nxt = score + 6'd1;
                  state_nxt = (len == 6'(MAX_LEN)) ? S_WIN : S_PAUSE;
               end else begin
                  idx_nxt = idx + 6'd1;
               end
            end else if (timer == TMO_LAST) begin
               state_nxt = S_LOSE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_PAUSE: begin
            if (timer == GAP_LAST) begin
               timer_nxt = '0;
               state_nxt = S_ADD;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign led_sel        = (state == S_SHOW_ON) ? (4'b0001 << cur) : 4'b0000;
   assign bus.led_green  = led_sel[0];
   assign bus.led_red    = led_sel[1];
   assign bus.led_blue   = led_sel[2];
   assign bus.led_yellow = led_sel[3];
   assign bus.player_wr  = (state == S_WAIT_INPUT);
   assign bus.game_over  = (state == S_LOSE);
   assign bus.win        = (state == S_WIN);
   assign bus.score      = score;
endmodule

// File: tb/tb_genius_sequencer.sv
// Randomized scoreboard bench for genius_sequencer: stimulus queues expected events, a negedge monitor checks them.
module tb_genius_sequencer;
   localparam int         MAX_LEN = 3;
   localparam int         SHOW    = 4;
   localparam int         GAP     = 2;
   localparam int         TMO     = 20;
   localparam logic [7:0] SEED    = 8'hA5;

   localparam int EV_LED = 0, EV_WR = 1, EV_LOSE = 2, EV_WIN = 3;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc;
   ev_t  expq[$];
   int   seq[$];
   int   score_m;
   int   led_rise_cyc = -1;

   genius_sequencer_if bus();

   genius_sequencer #(
      .MAX_LEN(MAX_LEN), .SHOW_TICKS(SHOW), .GAP_TICKS(GAP),
      .TIMEOUT_TICKS(TMO), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; the DUT LFSR has stepped exactly this many times.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   logic [3:0] leds;
   assign leds = {bus.led_yellow, bus.led_blue, bus.led_red, bus.led_green};

   function automatic logic [7:0] lfsr_at(int n);
      logic [7:0] v;
      v = SEED;
      for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
      return v;
   endfunction

   function automatic int colour_of(logic [3:0] l);
      case (l)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(string name, string msg);
      checks++;
      failures++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   task automatic push(int k, int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      expq.push_back(e);
   endtask

   task automatic push_round();
      foreach (seq[i]) push(EV_LED, seq[i]);
      push(EV_WR, score_m);
   endtask

   task automatic expect_ev(int k, int v);
      ev_t e;
      if (expq.size() == 0) begin
         fail("unexpected_event", $sformatf("kind %0d value %0d seen, none expected", k, v));
      end else begin
         e = expq.pop_front();
         check("event_kind", k, e.kind);
         check("event_value", v, e.val);
      end
   endtask

   // Monitor: turns output edges into events and compares them with the scoreboard.
   logic [3:0] prev_leds;
   logic       prev_wr, prev_go, prev_win;
   int         on_len;
   always @(negedge clk) begin
      if (rst) begin
         prev_leds = '0;
         prev_wr   = 1'b0;
         prev_go   = 1'b0;
         prev_win  = 1'b0;
         on_len    = 0;
      end else begin
         if (leds != 0 && prev_leds == 0) begin
            led_rise_cyc = cyc;
            expect_ev(EV_LED, colour_of(leds));
         end
         if (leds != 0) on_len++;
         else if (prev_leds != 0) begin
            check("led_width", on_len, SHOW);
            on_len = 0;
         end
         if (bus.player_wr && !prev_wr) expect_ev(EV_WR, int'(bus.score));
         if (bus.game_over && !prev_go) expect_ev(EV_LOSE, int'(bus.score));
         if (bus.win && !prev_win)      expect_ev(EV_WIN, int'(bus.score));
         prev_leds = leds;
         prev_wr   = bus.player_wr;
         prev_go   = bus.game_over;
         prev_win  = bus.win;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_game(output int n);
      logic [7:0] l;
      n = cyc;
      bus.start = 1'b1;
      seq.delete();
      score_m = 0;
      l = lfsr_at(n + 1);
      seq.push_back(int'(l[1:0]));
      push_round();
      tick();
      bus.start = 1'b0;
   endtask

   // Waits for the input window; throws ignored start/press pulses at SHOW_ON cycles meanwhile.
   task automatic wait_wr(output int w);
      int k;
      w = -1;
      k = 0;
      while (w < 0 && k < 400) begin
         if (bus.player_wr) begin
            bus.start       = 1'b0;
            bus.valid_press = 1'b0;
            w = cyc;
         end else begin
            if (leds != 0 && $urandom_range(0, 2) == 0) begin
               bus.start         = 1'b1;
               bus.valid_press   = 1'b1;
               bus.decoded_input = 2'($urandom_range(0, 3));
            end else begin
               bus.start       = 1'b0;
               bus.valid_press = 1'b0;
            end
            tick();
            k++;
         end
      end
      if (w < 0) fail("wait_player_wr", "player_wr never rose within 400 cycles");
   endtask

   task automatic press_step(int i, bit wrong);
      int p, c;
      logic [7:0] l;
      p = cyc;
      c = seq[i];
      if (wrong) begin
         c = (c + 1 + $urandom_range(0, 2)) % 4;
         push(EV_LOSE, score_m);
      end else if (i == seq.size() - 1) begin
         score_m++;
         if (seq.size() == MAX_LEN) push(EV_WIN, score_m);
         else begin
            l = lfsr_at(p + GAP + 1);
            seq.push_back(int'(l[1:0]));
            push_round();
         end
      end
      bus.valid_press   = 1'b1;
      bus.decoded_input = 2'(c);
      tick();
      bus.valid_press   = 1'b0;
      bus.decoded_input = 2'($urandom_range(0, 3));
   endtask

   task automatic check_quiet(string name);
      check({name, "_leds"}, int'(leds), 0);
      check({name, "_wr"}, int'(bus.player_wr), 0);
      check({name, "_game_over"}, int'(bus.game_over), 0);
      check({name, "_win"}, int'(bus.win), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int n, w, p, k, r, j;
      bit done;
      bus.start         = 1'b0;
      bus.valid_press   = 1'b0;
      bus.decoded_input = 2'b00;
      repeat (2) @(posedge clk);
      check_quiet("reset");
      check("reset_score", int'(bus.score), 0);
      #1;
      rst = 1'b0;
      tick();

      // Round 1 timing from a start pulse.
      start_game(n);
      wait_wr(w);
      check("t1_first_led_cycle", led_rise_cyc, n + 2);
      check("t1_player_wr_cycle", w, n + 8);
      check("t1_game_over", int'(bus.game_over), 0);
      check("t1_win", int'(bus.win), 0);

      // Correct replay, pause, then two-colour playback.
      p = cyc;
      press_step(0, 1'b0);
      check("t2_wr_drop", int'(bus.player_wr), 0);
      check("t2_score", int'(bus.score), 1);
      wait_wr(w);
      check("t2_wr_cycle", w, p + GAP + 2 + 2 * (SHOW + GAP));

      // Wrong second press.
      press_step(0, 1'b0);
      press_step(1, 1'b1);
      check("t3_game_over", int'(bus.game_over), 1);
      check("t3_wr", int'(bus.player_wr), 0);
      check("t3_score", int'(bus.score), 1);
      check("t3_leds", int'(leds), 0);
      start_game(n);
      check("t3_restart_game_over", int'(bus.game_over), 0);
      check("t3_restart_score", int'(bus.score), 0);

      // Timeout: 20 idle cycles lose; a press on the 20th cycle is accepted.
      wait_wr(w);
      repeat (TMO - 1) tick();
      check("t4_still_waiting", int'(bus.player_wr), 1);
      push(EV_LOSE, 0);
      tick();
      check("t4_timeout_lose", int'(bus.game_over), 1);
      check("t4_timeout_wr", int'(bus.player_wr), 0);
      start_game(n);
      wait_wr(w);
      repeat (TMO - 1) tick();
      press_step(0, 1'b0);
      check("t4_late_press_game_over", int'(bus.game_over), 0);
      check("t4_late_press_score", int'(bus.score), 1);

      // Finish rounds 2 and 3 to win; presses in WIN are ignored.
      for (int rnd = 2; rnd <= MAX_LEN; rnd++) begin
         wait_wr(w);
         for (int i = 0; i < rnd; i++) press_step(i, 1'b0);
      end
      check("t5_win", int'(bus.win), 1);
      check("t5_score", int'(bus.score), MAX_LEN);
      check("t5_wr", int'(bus.player_wr), 0);
      for (int i = 0; i < 4; i++) begin
         bus.valid_press   = 1'b1;
         bus.decoded_input = 2'($urandom_range(0, 3));
         tick();
         check("t5_win_held", int'(bus.win), 1);
         check("t5_score_held", int'(bus.score), MAX_LEN);
      end
      bus.valid_press = 1'b0;
      repeat (10) tick();
      check("t5_no_playback", expq.size(), 0);

      // Asynchronous reset in the middle of a round-2 SHOW_ON.
      start_game(n);
      check("t6_win_cleared", int'(bus.win), 0);
      wait_wr(w);
      press_step(0, 1'b0);
      k = 0;
      while (leds == 0 && k < 100) begin
         tick();
         k++;
      end
      if (leds == 0) fail("t6_wait_led", "no LED lit within 100 cycles");
      #2;
      rst = 1'b1;
      expq.delete();
      #1;
      check("t6_async_leds", int'(leds), 0);
      check("t6_async_score", int'(bus.score), 0);
      check("t6_async_wr", int'(bus.player_wr), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) tick();
      check_quiet("t6_idle");

      // Random games against the model.
      for (int g = 0; g < 4; g++) begin
         start_game(n);
         done = 1'b0;
         while (!done) begin
            wait_wr(w);
            if (w < 0) begin
               done = 1'b1;
            end else begin
               r = $urandom_range(0, 5);
               if (r == 0) begin
                  j = $urandom_range(0, seq.size() - 1);
                  for (int i = 0; i < j; i++) press_step(i, 1'b0);
                  press_step(j, 1'b1);
                  done = 1'b1;
               end else if (r == 1) begin
                  push(EV_LOSE, score_m);
                  repeat (TMO) tick();
                  done = 1'b1;
               end else begin
                  j = seq.size();
                  for (int i = 0; i < j; i++) press_step(i, 1'b0);
                  if (j == MAX_LEN) done = 1'b1;
               end
            end
         end
         check("rand_score", int'(bus.score), score_m);
      end

      repeat (5) tick();
      check("final_queue_empty", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
